kbd_token_sequencer: RTL and testbench

- Parametrised successor to the keyboard output mux.
- Turns keyboard strobes into an ordered token stream: number, operand, number, ... per expression.
- Tokens are buffered in a small FIFO and presented on a valid/ready interface to the ALU/controller. Tokens are not pulsed out unbuffered.
- Adds configurable operand count, token kind/last tagging, backpressure, clear-flush and overflow detection.

---
 rtl/kbd_pkg.sv | 19 +
 rtl/kbd_token_sequencer_if.sv | 48 ++++
 rtl/kbd_token_fifo.sv | 78 +++++++
 rtl/kbd_token_sequencer.sv | 91 +++++++++
 tb/tb_kbd_token_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard token sequencer.
package kbd_pkg;

   localparam int unsigned KBD_NUM_W = 8;
   localparam logic [3:0]  KEY_CLR   = 4'hD;

   typedef enum logic {
      TOK_NUM = 1'b0,
      TOK_OP  = 1'b1
   } tok_kind_t;

   // Default-width token; the sequencer builds its own token type for other NUM_W values.
   typedef struct packed {
      logic [KBD_NUM_W-1:0] data;
      tok_kind_t            kind;
      logic                 last;
   } kbd_token_t;

endpackage

// File: rtl/kbd_token_sequencer_if.sv
// Keyboard-side strobe inputs and consumer-side valid/ready token stream.
interface kbd_token_sequencer_if #(
   parameter int unsigned NUM_W = 8,
   parameter int unsigned OP_W  = 4,
   parameter int unsigned IDX_W = 2
);

   logic             key_strobe;
   logic [NUM_W-1:0] number;
   logic [OP_W-1:0]  operand;
   logic             ovf_clr;
   logic             out_valid;
   logic             out_ready;
   logic [NUM_W-1:0] out_data;
   logic             out_kind;
   logic             out_last;
   logic [IDX_W-1:0] seq_idx;
   logic             overflow;

   modport master (
      output key_strobe,
      output number,
      output operand,
      output ovf_clr,
      output out_ready,
      input  out_valid,
      input  out_data,
      input  out_kind,
      input  out_last,
      input  seq_idx,
      input  overflow
   );

   modport slave (
      input  key_strobe,
      input  number,
      input  operand,
      input  ovf_clr,
      input  out_ready,
      output out_valid,
      output out_data,
      output out_kind,
      output out_last,
      output seq_idx,
      output overflow
   );

endinterface

// File: rtl/kbd_token_fifo.sv
// Synchronous token FIFO with flush; while empty the head shows the last popped token.
module kbd_token_fifo
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         token_t = kbd_token_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  token_t wdata_i,
   input  logic   pop_i,
   input  logic   flush_i,
   output logic   full_o,
   output logic   empty_o,
   output token_t head_o
);

   localparam int unsigned     PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);

   token_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   token_t             last_q, last_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

   // Storage needs no reset: it is only visible through head_o while count_q is non-zero.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/kbd_token_sequencer.sv
// Orders keyboard strobes into number/operand token expressions and buffers them for a consumer.
module kbd_token_sequencer
   import kbd_pkg::*;
#(
   parameter int unsigned      NUM_W      = 8,
   parameter int unsigned      OP_W       = 4,
   parameter int unsigned      N_NUMS     = 2,
   parameter logic [OP_W-1:0]  CLR_CODE   = OP_W'(KEY_CLR),
   parameter int unsigned      FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   kbd_token_sequencer_if.slave  bus
);

   localparam int unsigned      SEQ_LEN  = 2 * N_NUMS - 1;
   localparam int unsigned      IDX_W    = $clog2(SEQ_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

   typedef struct packed {
      logic [NUM_W-1:0] data;
      tok_kind_t        kind;
      logic             last;
   } token_t;

   logic [IDX_W-1:0] seq_idx_q, seq_idx_d;
   logic             ovf_q, ovf_d;
   logic             clr, cap, pop, push, drop;
   logic             fifo_full, fifo_empty;
   token_t           tok, head;

   always_comb begin
      clr  = bus.key_strobe && (bus.operand == CLR_CODE);
      cap  = bus.key_strobe && !clr;
      // A clear voids any pop so the held "last popped" token is not disturbed.
      pop  = !fifo_empty && bus.out_ready && !clr;
      push = cap && (!fifo_full || pop);
      drop = cap && !push;

      tok.data = seq_idx_q[0] ? NUM_W'(bus.operand) : bus.number;
      tok.kind = seq_idx_q[0] ? TOK_OP : TOK_NUM;
      tok.last = (seq_idx_q == IDX_LAST);

      seq_idx_d = seq_idx_q;
      if (clr) begin
         seq_idx_d = '0;
      end else if (push) begin
         seq_idx_d = tok.last ? '0 : seq_idx_q + 1'b1;
      end

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         seq_idx_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         seq_idx_q <= seq_idx_d;
         ovf_q     <= ovf_d;
      end
   end

   kbd_token_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .token_t (token_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (tok),
      .pop_i   (pop),
      .flush_i (clr),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = head.data;
   assign bus.out_kind  = head.kind;
   assign bus.out_last  = head.last;
   assign bus.seq_idx   = seq_idx_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_kbd_token_sequencer.sv
// Bench for kbd_token_sequencer: vector table plus a queue-based reference model for N_NUMS=2.
module tb_kbd_token_sequencer;

   typedef struct packed {
      logic [7:0] data;
      logic       kind;
      logic       last;
   } tok_t;

   typedef struct {
      logic       sel;
      logic [7:0] number;
      logic [3:0] operand;
      logic [7:0] exp_data;
      logic       exp_kind;
      logic       exp_last;
      logic [2:0] exp_idx;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   kbd_token_sequencer_if #(.NUM_W(8), .OP_W(4), .IDX_W(2)) bus2 ();
   kbd_token_sequencer_if #(.NUM_W(8), .OP_W(4), .IDX_W(3)) bus3 ();

   kbd_token_sequencer #(
      .NUM_W(8), .OP_W(4), .N_NUMS(2), .CLR_CODE(4'hD), .FIFO_DEPTH(4)
   ) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   kbd_token_sequencer #(
      .NUM_W(8), .OP_W(4), .N_NUMS(3), .CLR_CODE(4'hD), .FIFO_DEPTH(4)
   ) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mdl_en   = 1'b0;
   tok_t sb_q[$];
   tok_t sb_last;
   tok_t m_tok;
   logic [1:0] m_idx;
   logic m_ovf;
   logic m_drop;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] hd2();
      return 32'({bus2.out_data, bus2.out_kind, bus2.out_last});
   endfunction

   function automatic logic [31:0] hd3();
      return 32'({bus3.out_data, bus3.out_kind, bus3.out_last});
   endfunction

   // Reference model for u_dut2: compare its visible state, then advance on the sampled inputs.
   task automatic model_step();
      chk("sb_valid", 32'(bus2.out_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) chk("sb_head", hd2(), 32'(sb_q[0]));
      else                  chk("sb_hold", hd2(), 32'(sb_last));
      chk("sb_idx", 32'(bus2.seq_idx), 32'(m_idx));
      chk("sb_ovf", 32'(bus2.overflow), 32'(m_ovf));
      if (!rst) begin
         sb_q.delete();
         sb_last = '0;
         m_idx   = 2'd0;
         m_ovf   = 1'b0;
      end else if (bus2.key_strobe && bus2.operand == 4'hD) begin
         sb_q.delete();
         m_idx = 2'd0;
         if (bus2.ovf_clr) m_ovf = 1'b0;
      end else begin
         m_drop = 1'b0;
         if (sb_q.size() != 0 && bus2.out_ready) sb_last = sb_q.pop_front();
         if (bus2.key_strobe) begin
            if (sb_q.size() < 4) begin
               m_tok.data = m_idx[0] ? {4'h0, bus2.operand} : bus2.number;
               m_tok.kind = m_idx[0];
               m_tok.last = (m_idx == 2'd2);
               sb_q.push_back(m_tok);
               m_idx = (m_idx == 2'd2) ? 2'd0 : m_idx + 2'd1;
            end else begin
               m_drop = 1'b1;
            end
         end
         if (m_drop) m_ovf = 1'b1;
         else if (bus2.ovf_clr) m_ovf = 1'b0;
      end
   endtask

   // Inputs change 2 time units after the rising edge; the model samples on the falling edge.
   task automatic tick();
      @(negedge clk);
      if (mdl_en) model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic strobe2(input logic [7:0] num, input logic [3:0] op);
      bus2.key_strobe = 1'b1;
      bus2.number     = num;
      bus2.operand    = op;
      tick();
      bus2.key_strobe = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b0, 8'h12, 4'h0, 8'h12, 1'b0, 1'b0, 3'd1};
      tbl[1] = '{1'b0, 8'h99, 4'h1, 8'h01, 1'b1, 1'b0, 3'd2};
      tbl[2] = '{1'b0, 8'h34, 4'h0, 8'h34, 1'b0, 1'b1, 3'd0};
      tbl[3] = '{1'b1, 8'h10, 4'h0, 8'h10, 1'b0, 1'b0, 3'd1};
      tbl[4] = '{1'b1, 8'hAA, 4'h2, 8'h02, 1'b1, 1'b0, 3'd2};
      tbl[5] = '{1'b1, 8'h20, 4'h0, 8'h20, 1'b0, 1'b0, 3'd3};
      tbl[6] = '{1'b1, 8'hBB, 4'h3, 8'h03, 1'b1, 1'b0, 3'd4};
      tbl[7] = '{1'b1, 8'h30, 4'h0, 8'h30, 1'b0, 1'b1, 3'd0};
      tbl[8] = '{1'b1, 8'h40, 4'h0, 8'h40, 1'b0, 1'b0, 3'd1};

      rst = 1'b0;
      bus2.key_strobe = 1'b0; bus2.number = '0; bus2.operand = '0;
      bus2.ovf_clr = 1'b0; bus2.out_ready = 1'b0;
      bus3.key_strobe = 1'b0; bus3.number = '0; bus3.operand = '0;
      bus3.ovf_clr = 1'b0; bus3.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(bus2.out_valid), 0);
      chk("rst_head", hd2(), 0);
      chk("rst_idx", 32'(bus2.seq_idx), 0);
      chk("rst_ovf", 32'(bus2.overflow), 0);
      chk("rst3_valid", 32'(bus3.out_valid), 0);
      chk("rst3_idx", 32'(bus3.seq_idx), 0);
      rst = 1'b1;
      sb_q.delete(); sb_last = '0; m_idx = 2'd0; m_ovf = 1'b0;
      mdl_en = 1'b1;

      // Back-to-back strobes with the consumer always ready: each token is head one cycle later.
      bus2.out_ready = 1'b1;
      bus3.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].sel == 1'b0) begin
            bus2.key_strobe = 1'b1; bus2.number = tbl[i].number; bus2.operand = tbl[i].operand;
         end else begin
            bus3.key_strobe = 1'b1; bus3.number = tbl[i].number; bus3.operand = tbl[i].operand;
         end
         tick();
         bus2.key_strobe = 1'b0;
         bus3.key_strobe = 1'b0;
         if (tbl[i].sel == 1'b0) begin
            chk($sformatf("tbl%0d_valid", i), 32'(bus2.out_valid), 1);
            chk($sformatf("tbl%0d_head", i), hd2(),
                32'({tbl[i].exp_data, tbl[i].exp_kind, tbl[i].exp_last}));
            chk($sformatf("tbl%0d_idx", i), 32'(bus2.seq_idx), 32'(tbl[i].exp_idx));
         end else begin
            chk($sformatf("tbl%0d_valid", i), 32'(bus3.out_valid), 1);
            chk($sformatf("tbl%0d_head", i), hd3(),
                32'({tbl[i].exp_data, tbl[i].exp_kind, tbl[i].exp_last}));
            chk($sformatf("tbl%0d_idx", i), 32'(bus3.seq_idx), 32'(tbl[i].exp_idx));
         end
      end
      tick();
      chk("empty_valid", 32'(bus2.out_valid), 0);
      chk("empty_hold", hd2(), 32'({8'h34, 1'b0, 1'b1}));
      bus3.out_ready = 1'b0;

      // Backpressure: four tokens fit, the 5th and 6th strobes are dropped.
      bus2.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         strobe2(8'h40 + 8'(i), 4'h5);
         if (i == 3) chk("ovf_before_drop", 32'(bus2.overflow), 0);
         if (i == 4) chk("ovf_after_5th", 32'(bus2.overflow), 1);
      end
      chk("idx_stall", 32'(bus2.seq_idx), 1);
      chk("held_head", hd2(), 32'({8'h40, 1'b0, 1'b0}));

      bus2.ovf_clr = 1'b1;
      strobe2(8'h50, 4'h5);
      chk("ovf_set_wins", 32'(bus2.overflow), 1);
      tick();
      bus2.ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(bus2.overflow), 0);

      // Full FIFO: a strobe with a concurrent pop is accepted and the count stays at four.
      bus2.out_ready = 1'b1;
      strobe2(8'h66, 4'h5);
      chk("full_pop_ovf", 32'(bus2.overflow), 0);
      chk("full_pop_idx", 32'(bus2.seq_idx), 2);
      chk("full_pop_head", hd2(), 32'({8'h05, 1'b1, 1'b0}));
      bus2.out_ready = 1'b0;
      strobe2(8'h67, 4'h5);
      chk("full_count_kept", 32'(bus2.overflow), 1);
      bus2.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("drain_valid", 32'(bus2.out_valid), 0);
      chk("drain_hold", hd2(), 32'({8'h05, 1'b1, 1'b0}));

      // Clear with two tokens buffered and a simultaneous ready: everything flushes.
      bus2.out_ready = 1'b0;
      strobe2(8'h21, 4'h0);
      strobe2(8'h22, 4'h0);
      chk("pre_clr_valid", 32'(bus2.out_valid), 1);
      bus2.out_ready = 1'b1;
      strobe2(8'hEE, 4'hD);
      bus2.out_ready = 1'b0;
      chk("clr_valid", 32'(bus2.out_valid), 0);
      chk("clr_idx", 32'(bus2.seq_idx), 0);
      chk("clr_keeps_ovf", 32'(bus2.overflow), 1);
      chk("clr_hold", hd2(), 32'({8'h05, 1'b1, 1'b0}));
      strobe2(8'h77, 4'h0);
      chk("post_clr_head", hd2(), 32'({8'h77, 1'b0, 1'b0}));
      chk("post_clr_idx", 32'(bus2.seq_idx), 1);

      // Reset mid-expression with three tokens buffered.
      bus2.out_ready = 1'b1;
      tick();
      bus2.out_ready = 1'b0;
      strobe2(8'h00, 4'h3);
      strobe2(8'h88, 4'h0);
      strobe2(8'h99, 4'h0);
      chk("pre_rst_idx", 32'(bus2.seq_idx), 1);
      rst = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(bus2.out_valid), 0);
      chk("mid_rst_head", hd2(), 0);
      chk("mid_rst_idx", 32'(bus2.seq_idx), 0);
      chk("mid_rst_ovf", 32'(bus2.overflow), 0);
      rst = 1'b1;
      tick();
      strobe2(8'h5A, 4'h0);
      chk("post_rst_head", hd2(), 32'({8'h5A, 1'b0, 1'b0}));
      chk("post_rst_idx", 32'(bus2.seq_idx), 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
